reset_sequencer: RTL and testbench

//  Multi-channel power-on/reboot reset generator. Holds NUM_CH active-high resets after power-up.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_req_filter.sv | 43 ++++
 rtl/reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_reset_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Holds the sequencer state enum and a max3 constant function that sizes the shared counter.
// No ports; imported by reset_sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT_ACK,
    GAP,
    DONE
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/reset_req_filter.sv
// Purpose: synchronise an async restart request and accept it only after FILTER_LEN consecutive high samples.
// Latency: req_filt rises 2 + FILTER_LEN edges after the pin goes high; it falls on the first synced low sample.
// Backpressure: none.
// Ports: clk, reset_n (async active-low), req_async (raw pin) -> req_filt (registered, filtered level).
module reset_req_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_async,
  output logic req_filt
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] RUN_LAST = FCW'(FILTER_LEN - 1);

  logic           sync1;
  logic           sync2;
  logic [FCW-1:0] run_cnt;

  // run_cnt saturates at FILTER_LEN-1; the sample that finds it there is the
  // FILTER_LEN-th consecutive high one and raises req_filt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      run_cnt  <= '0;
      req_filt <= 1'b0;
    end else begin
      sync1 <= req_async;
      sync2 <= sync1;
      if (!sync2) begin
        run_cnt  <= '0;
        req_filt <= 1'b0;
      end else if (run_cnt == RUN_LAST) begin
        req_filt <= 1'b1;
      end else begin
        run_cnt <= run_cnt + FCW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Purpose: multi-channel reset generator; holds all resets, then releases channels 0..NUM_CH-1 in order.
// Latency: first release HOLD_CYCLES edges after reset_n / restart drop; STEP_CYCLES gap after each ack/timeout.
// Backpressure: none; optional per-channel ack handshake bounded by ACK_TIMEOUT (0 = ack ignored).
// Ports: clk, reset_n (async active-low), ext_reset_req (async, filtered), ch_ack[NUM_CH] (sync)
//        -> reset_out[NUM_CH] (active high), seq_done, ack_timeout[NUM_CH] (sticky). All outputs registered.
// Build option: define RESET_SEQ_SOFT_REQ_EN to add soft_reset_req, a synchronous single-cycle restart pulse.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 3700000,
  parameter int STEP_CYCLES = 100,
  parameter int ACK_TIMEOUT = 0,
  parameter int FILTER_LEN  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ext_reset_req,
`ifdef RESET_SEQ_SOFT_REQ_EN
  input  logic              soft_reset_req,
`endif
  input  logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] reset_out,
  output logic              seq_done,
  output logic [NUM_CH-1:0] ack_timeout
);

  localparam int CW = $clog2(max3(HOLD_CYCLES, STEP_CYCLES, ACK_TIMEOUT) + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Compare values: the counter starts at 0 on state entry, so the edge that
  // finds it at N-1 is the N-th edge in that state.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  logic req_filt;
  logic restart;

  reset_req_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_req_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_async (ext_reset_req),
    .req_filt  (req_filt)
  );

`ifdef RESET_SEQ_SOFT_REQ_EN
  assign restart = req_filt | soft_reset_req;
`else
  assign restart = req_filt;
`endif

  seq_state_t        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [NUM_CH-1:0] rst_nxt;
  logic              done_nxt;
  logic [NUM_CH-1:0] tmo_nxt;
  logic              wait_exit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      reset_out   <= '1;
      seq_done    <= 1'b0;
      ack_timeout <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      reset_out   <= rst_nxt;
      seq_done    <= done_nxt;
      ack_timeout <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_nxt   = reset_out;
    done_nxt  = seq_done;
    tmo_nxt   = ack_timeout;
    wait_exit = 1'b0;

    // Restart overrides whatever the sequence would have done this edge, and
    // keeps cnt pinned at 0 for as long as the request is held.
    if (restart) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rst_nxt   = '1;
      done_nxt  = 1'b0;
      tmo_nxt   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_nxt[0] = 1'b0;
            cnt_nxt    = '0;
            idx_nxt    = '0;
            state_nxt  = WAIT_ACK;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        WAIT_ACK: begin
          if (ACK_TIMEOUT == 0) begin
            wait_exit = 1'b1;
          end else if (ch_ack[idx]) begin
            wait_exit = 1'b1;
          end else if (cnt == TO_LAST) begin
            wait_exit    = 1'b1;
            tmo_nxt[idx] = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
          if (wait_exit) begin
            cnt_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = GAP;
            end
          end
        end

        GAP: begin
          if (cnt == STEP_LAST) begin
            idx_nxt          = idx + IW'(1);
            rst_nxt[idx_nxt] = 1'b0;
            cnt_nxt          = '0;
            state_nxt        = WAIT_ACK;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        // Channel release happens on the edge that leaves HOLD/GAP, so this
        // state is never occupied; should it ever be, resume the ack wait.
        RELEASE: state_nxt = WAIT_ACK;

        DONE: state_nxt = DONE;

        default: state_nxt = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (no handshake, and ACK_TIMEOUT=10) sharing all inputs.
// A history-based model derives expected outputs from edges-since-count-start and recorded acks.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int H    = 20;
  localparam int S    = 5;
  localparam int TO1  = 10;
  localparam int FL   = 4;
  localparam int HIST = 4096;

  logic         clk;
  logic         reset_n;
  logic         ext_reset_req;
  logic         soft_reset_req;
  logic [N-1:0] ch_ack;
  logic [N-1:0] dut0_rst, dut0_tmo, dut1_rst, dut1_tmo;
  logic         dut0_done, dut1_done;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(.NUM_CH(N), .HOLD_CYCLES(H), .STEP_CYCLES(S), .ACK_TIMEOUT(0), .FILTER_LEN(FL)) dut0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .ext_reset_req (ext_reset_req),
`ifdef RESET_SEQ_SOFT_REQ_EN
    .soft_reset_req(soft_reset_req),
`endif
    .ch_ack        (ch_ack),
    .reset_out     (dut0_rst),
    .seq_done      (dut0_done),
    .ack_timeout   (dut0_tmo)
  );

  reset_sequencer #(.NUM_CH(N), .HOLD_CYCLES(H), .STEP_CYCLES(S), .ACK_TIMEOUT(TO1), .FILTER_LEN(FL)) dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .ext_reset_req (ext_reset_req),
`ifdef RESET_SEQ_SOFT_REQ_EN
    .soft_reset_req(soft_reset_req),
`endif
    .ch_ack        (ch_ack),
    .reset_out     (dut1_rst),
    .seq_done      (dut1_done),
    .ack_timeout   (dut1_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // t = edges since HOLD counting began (0 while held in reset/restart).
  // ack_hist[j] = ch_ack sampled on the edge where t became j.
  int            t = 0;
  logic [N-1:0]  ack_hist [0:HIST-1];
  logic [FL+1:0] pin_sh;  // pin_sh[k] = pin sampled k+1 edges ago
  wire           model_restart = soft_reset_req | (&pin_sh[FL+1:2]);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t      <= 0;
      pin_sh <= '0;
    end else begin
      pin_sh <= {pin_sh[FL:0], ext_reset_req};
      if (model_restart) begin
        t <= 0;
      end else if (t < HIST - 1) begin
        t              <= t + 1;
        ack_hist[t + 1] <= ch_ack;
      end
    end
  end

  // Walk the channels in order: channel i is released at r, leaves the ack
  // wait at the first acked edge (or after 'to' edges), next release S later.
  function automatic void model_out(input int tt, input int to,
                                    output logic [N-1:0] rst, output logic done,
                                    output logic [N-1:0] tmo);
    int r, ex;
    rst  = '1;
    done = 1'b0;
    tmo  = '0;
    r    = H;
    for (int i = 0; i < N; i++) begin
      if (tt < r) return;
      rst[i] = 1'b0;
      ex = -1;
      if (to == 0) begin
        ex = r + 1;
      end else begin
        for (int k = 1; k <= to; k++)
          if (ex < 0 && (r + k) <= tt && ack_hist[r + k][i]) ex = r + k;
        if (ex < 0) begin
          ex = r + to;
          if (ex <= tt) tmo[i] = 1'b1;
        end
      end
      if (ex > tt) return;
      if (i == N - 1) done = 1'b1;
      r = ex + S;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] er0, et0, er1, et1;
    logic         ed0, ed1;
    model_out(t, 0, er0, ed0, et0);
    model_out(t, TO1, er1, ed1, et1);
    chk("model dut0 reset_out",   32'(dut0_rst),  32'(er0));
    chk("model dut0 seq_done",    32'(dut0_done), 32'(ed0));
    chk("model dut0 ack_timeout", 32'(dut0_tmo),  32'(et0));
    chk("model dut1 reset_out",   32'(dut1_rst),  32'(er1));
    chk("model dut1 seq_done",    32'(dut1_done), 32'(ed1));
    chk("model dut1 ack_timeout", 32'(dut1_tmo),  32'(et1));
  end

  // ---------------- stimulus ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n        = 1'b1;
    ext_reset_req  = 1'b0;
    soft_reset_req = 1'b0;
    ch_ack         = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #8 reset_n = 1'b1;  // next posedge is edge 1

    // Sequence timing: no-handshake and timeout instances
    edges(19);
    chk("e19 dut0 reset_out", 32'(dut0_rst), 32'hF);
    chk("e19 dut1 reset_out", 32'(dut1_rst), 32'hF);
    edges(1);
    chk("e20 dut0 reset_out", 32'(dut0_rst), 32'hE);
    chk("e20 dut1 reset_out", 32'(dut1_rst), 32'hE);
    edges(2);
    ch_ack = 4'b1101;  // ack[0] sampled at edge 23; ack[1] never
    edges(4);
    chk("e26 dut0 reset_out", 32'(dut0_rst), 32'hC);
    edges(2);
    chk("e28 dut1 reset_out", 32'(dut1_rst), 32'hC);
    edges(4);
    chk("e32 dut0 reset_out", 32'(dut0_rst), 32'h8);
    edges(5);
    chk("e37 dut1 ack_timeout", 32'(dut1_tmo), 32'h0);
    edges(1);
    chk("e38 dut0 reset_out",   32'(dut0_rst),  32'h0);
    chk("e38 dut0 seq_done",    32'(dut0_done), 32'h0);
    chk("e38 dut1 ack_timeout", 32'(dut1_tmo),  32'h2);
    edges(1);
    chk("e39 dut0 seq_done", 32'(dut0_done), 32'h1);
    edges(10);
    chk("e49 dut1 reset_out", 32'(dut1_rst),  32'h0);
    chk("e49 dut1 seq_done",  32'(dut1_done), 32'h0);
    edges(1);
    chk("e50 dut1 seq_done",    32'(dut1_done), 32'h1);
    chk("e50 dut1 ack_timeout", 32'(dut1_tmo),  32'h2);

    // Request filter: 1- and 3-cycle pulses rejected
    edges(5);
    ext_reset_req = 1'b1; edges(1); ext_reset_req = 1'b0;
    edges(10);
    ext_reset_req = 1'b1; edges(3); ext_reset_req = 1'b0;
    edges(10);
    chk("short pulses dut0 seq_done",    32'(dut0_done), 32'h1);
    chk("short pulses dut1 ack_timeout", 32'(dut1_tmo),  32'h2);

    // 4-cycle pulse: restart at 2+4+1 edges after the pulse is first sampled
    ext_reset_req = 1'b1; edges(4); ext_reset_req = 1'b0;
    edges(2);
    chk("pulse4 +6 dut0 seq_done", 32'(dut0_done), 32'h1);
    edges(1);
    chk("pulse4 +7 dut0 reset_out",   32'(dut0_rst),  32'hF);
    chk("pulse4 +7 dut0 seq_done",    32'(dut0_done), 32'h0);
    chk("pulse4 +7 dut1 ack_timeout", 32'(dut1_tmo),  32'h0);

    // Held request mid-GAP (dut0 at t=23)
    edges(23);
    ext_reset_req = 1'b1;
    edges(50);
    ext_reset_req = 1'b0;
    chk("held req dut0 reset_out", 32'(dut0_rst), 32'hF);
    chk("held req dut1 reset_out", 32'(dut1_rst), 32'hF);
    edges(22);
    chk("held req +72 dut0 reset_out", 32'(dut0_rst), 32'hF);
    edges(1);
    chk("held req +73 dut0 reset_out", 32'(dut0_rst), 32'hE);

    // reset_n pulse mid-WAIT_ACK: outputs reset before the next edge
    #1 reset_n = 1'b0;
    #1;
    chk("async rst dut0 reset_out", 32'(dut0_rst),  32'hF);
    chk("async rst dut1 reset_out", 32'(dut1_rst),  32'hF);
    chk("async rst dut0 seq_done",  32'(dut0_done), 32'h0);
    #4 reset_n = 1'b1;
    edges(19);
    chk("replay e19 dut0 reset_out", 32'(dut0_rst), 32'hF);
    edges(1);
    chk("replay e20 dut0 reset_out", 32'(dut0_rst), 32'hE);

`ifdef RESET_SEQ_SOFT_REQ_EN
    // Soft pulse on the same edge as the last channel's ack: restart wins
    edges(27);
    chk("e47 dut1 reset_out", 32'(dut1_rst), 32'h0);
    soft_reset_req = 1'b1;
    edges(1);
    soft_reset_req = 1'b0;
    chk("soft dut1 seq_done",    32'(dut1_done), 32'h0);
    chk("soft dut1 reset_out",   32'(dut1_rst),  32'hF);
    chk("soft dut1 ack_timeout", 32'(dut1_tmo),  32'h0);
    edges(30);
`else
    edges(40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
